// File: rtl/pipeline_control_unit_pkg.sv
// Shared constants for the pipeline control unit: opcodes (instr[6:2]),
// ALUOp encodings and control-word flag positions above the ALUOp field.
package pipeline_control_unit_pkg;

  localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
  localparam logic [4:0] OPCODE_CUSTOM0  = 5'b00010;
  localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
  localparam logic [4:0] OPCODE_STORE    = 5'b01000;
  localparam logic [4:0] OPCODE_CUSTOM1  = 5'b01010;
  localparam logic [4:0] OPCODE_OP       = 5'b01100;
  localparam logic [4:0] OPCODE_LUI      = 5'b01101;
  localparam logic [4:0] OPCODE_CUSTOM2  = 5'b10110;
  localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
  localparam logic [4:0] OPCODE_JALR     = 5'b11001;
  localparam logic [4:0] OPCODE_JAL      = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;
  localparam logic [4:0] OPCODE_CUSTOM3  = 5'b11110;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_PASSB  = 2'b11;

  // Flag offsets counted from the LSB of the flag field; ALUOp sits below.
  localparam int CWF_SYS      = 0;
  localparam int CWF_LUI      = 1;
  localparam int CWF_AUIPC    = 2;
  localparam int CWF_REGWRITE = 3;
  localparam int CWF_ALUSRC   = 4;
  localparam int CWF_MEMTOREG = 5;
  localparam int CWF_MEMWRITE = 6;
  localparam int CWF_MEMREAD  = 7;
  localparam int CWF_JALR     = 8;
  localparam int CWF_JUMP     = 9;
  localparam int CWF_BRANCH   = 10;
  localparam int CW_FLAGS     = 11;

  function automatic int cw_width(input int aluop_w);
    return CW_FLAGS + aluop_w;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_main_decoder.sv
// Combinational main decoder: opcode -> control word, illegal flag and
// source-register usage. Unknown opcodes yield an all-zero word.
module main_decoder
  import pipeline_control_unit_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic [4:0]                  opcode,
  output logic [CW_FLAGS+ALUOP_W-1:0] cw,
  output logic                        illegal,
  output logic                        uses_rs1,
  output logic                        uses_rs2
);

  logic [CW_FLAGS-1:0] flags;
  logic [1:0]          aluop;

  always_comb begin
    flags    = '0;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPCODE_OP: begin
        flags[CWF_REGWRITE] = 1'b1;
        aluop    = ALUOP_FUNCT;
        uses_rs2 = 1'b1;
      end
      OPCODE_OP_IMM: begin
        flags[CWF_ALUSRC]   = 1'b1;
        flags[CWF_REGWRITE] = 1'b1;
        aluop = ALUOP_FUNCT;
      end
      OPCODE_LOAD: begin
        flags[CWF_MEMREAD]  = 1'b1;
        flags[CWF_MEMTOREG] = 1'b1;
        flags[CWF_ALUSRC]   = 1'b1;
        flags[CWF_REGWRITE] = 1'b1;
      end
      OPCODE_STORE: begin
        flags[CWF_MEMWRITE] = 1'b1;
        flags[CWF_ALUSRC]   = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPCODE_BRANCH: begin
        flags[CWF_BRANCH] = 1'b1;
        aluop    = ALUOP_BRANCH;
        uses_rs2 = 1'b1;
      end
      OPCODE_JAL: begin
        flags[CWF_JUMP]     = 1'b1;
        flags[CWF_REGWRITE] = 1'b1;
        uses_rs1 = 1'b0;
      end
      OPCODE_JALR: begin
        flags[CWF_JUMP]     = 1'b1;
        flags[CWF_JALR]     = 1'b1;
        flags[CWF_ALUSRC]   = 1'b1;
        flags[CWF_REGWRITE] = 1'b1;
      end
      OPCODE_AUIPC: begin
        flags[CWF_AUIPC]    = 1'b1;
        flags[CWF_ALUSRC]   = 1'b1;
        flags[CWF_REGWRITE] = 1'b1;
        uses_rs1 = 1'b0;
      end
      OPCODE_LUI: begin
        flags[CWF_LUI]      = 1'b1;
        flags[CWF_ALUSRC]   = 1'b1;
        flags[CWF_REGWRITE] = 1'b1;
        aluop    = ALUOP_PASSB;
        uses_rs1 = 1'b0;
      end
      OPCODE_SYSTEM, OPCODE_CUSTOM0, OPCODE_CUSTOM1,
      OPCODE_CUSTOM2, OPCODE_CUSTOM3: begin
        flags[CWF_SYS] = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
    cw = {flags, ALUOP_W'(aluop)};
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Decode-plus-hazard control for a single-memory 5-stage RV32I pipeline:
// ID/EX, EX/MEM, MEM/WB control registers, stall/flush and a sticky halt.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int ALUOP_W     = 2,
  parameter int SHARED_MEM  = 1,
  parameter int HALT_ON_SYS = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    opcode_id,
  input  logic [REG_ADDR_W-1:0]         rs1_id,
  input  logic [REG_ADDR_W-1:0]         rs2_id,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          redirect_ex,
  output logic                          illegal_id,
  output logic                          pc_write,
  output logic                          ifid_write,
  output logic                          ifid_bubble,
  output logic [CW_FLAGS+ALUOP_W-1:0]   ex_ctrl,
  output logic                          mem_memread,
  output logic                          mem_memwrite,
  output logic                          mem_regwrite,
  output logic                          mem_memtoreg,
  output logic                          wb_regwrite,
  output logic                          wb_memtoreg,
  output logic                          halted
);

  localparam int CW_W    = cw_width(ALUOP_W);
  localparam int B_MR    = ALUOP_W + CWF_MEMREAD;
  localparam int B_MW    = ALUOP_W + CWF_MEMWRITE;
  localparam int B_RW    = ALUOP_W + CWF_REGWRITE;
  localparam int B_M2R   = ALUOP_W + CWF_MEMTOREG;
  localparam int B_SYS   = ALUOP_W + CWF_SYS;

  logic [CW_W-1:0] dec_cw;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            mem_sys_reg;
  logic            wb_sys_reg;
  logic            lu;
  logic            memb;
  logic            idex_bubble;

  main_decoder #(.ALUOP_W(ALUOP_W)) u_main_decoder (
    .opcode   (opcode_id),
    .cw       (dec_cw),
    .illegal  (illegal_id),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign lu = ex_ctrl[B_MR] && (ex_rd != '0) &&
              ((uses_rs1 && (ex_rd == rs1_id)) || (uses_rs2 && (ex_rd == rs2_id)));
  assign memb = (SHARED_MEM != 0) && (mem_memread || mem_memwrite);

  // Priority: halted > redirect > load-use > memory busy.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_bubble = 1'b0;
    if (halted) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (redirect_ex) begin
      ifid_bubble = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (memb) begin
      pc_write    = 1'b0;
      ifid_bubble = 1'b1;
    end
  end

  assign idex_bubble = halted || redirect_ex || lu;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_ctrl      <= '0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_sys_reg  <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_sys_reg   <= 1'b0;
      halted       <= 1'b0;
    end else begin
      ex_ctrl      <= idex_bubble ? '0 : dec_cw;
      mem_memread  <= ex_ctrl[B_MR];
      mem_memwrite <= ex_ctrl[B_MW];
      mem_regwrite <= ex_ctrl[B_RW];
      mem_memtoreg <= ex_ctrl[B_M2R];
      mem_sys_reg  <= ex_ctrl[B_SYS];
      wb_regwrite  <= mem_regwrite;
      wb_memtoreg  <= mem_memtoreg;
      wb_sys_reg   <= mem_sys_reg;
      if ((HALT_ON_SYS != 0) && wb_sys_reg)
        halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized bench for pipeline_control_unit against a stage-by-stage
// instruction model built directly from the decode table and hazard rules.
module tb_pipeline_control_unit;

  typedef struct packed {
    logic branch, jump, jalr, memread, memwrite, memtoreg, alusrc,
          regwrite, auipc, lui, sys;
    logic [1:0] aluop;
  } cw_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  opcode_id = '0, rs1_id = '0, rs2_id = '0, ex_rd = '0;
  logic        redirect_ex = 1'b0;
  logic        illegal_id, pc_write, ifid_write, ifid_bubble;
  logic [12:0] ex_ctrl;
  logic        mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg;
  logic        wb_regwrite, wb_memtoreg, halted;
  logic        ns_illegal, ns_pc_write, ns_ifid_write, ns_ifid_bubble;
  logic [12:0] ns_ex_ctrl;
  logic        ns_mr, ns_mw, ns_mrw, ns_m2r, ns_wrw, ns_wm2r, ns_halted;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  cw_t  m_ex, m_mem, m_wb;
  logic m_halted;

  always #5 clk = ~clk;

  pipeline_control_unit dut (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .ex_rd(ex_rd), .redirect_ex(redirect_ex), .illegal_id(illegal_id),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_bubble(ifid_bubble),
    .ex_ctrl(ex_ctrl), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .halted(halted)
  );

  pipeline_control_unit #(.SHARED_MEM(0)) dut_ns (
    .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .ex_rd(ex_rd), .redirect_ex(redirect_ex), .illegal_id(ns_illegal),
    .pc_write(ns_pc_write), .ifid_write(ns_ifid_write), .ifid_bubble(ns_ifid_bubble),
    .ex_ctrl(ns_ex_ctrl), .mem_memread(ns_mr), .mem_memwrite(ns_mw),
    .mem_regwrite(ns_mrw), .mem_memtoreg(ns_m2r),
    .wb_regwrite(ns_wrw), .wb_memtoreg(ns_wm2r), .halted(ns_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic decode(input logic [4:0] op, output cw_t c, output logic ill,
                        output logic u1, output logic u2);
    c = '0; ill = 1'b0; u1 = 1'b1; u2 = 1'b0;
    case (op)
      5'b01100: begin c.regwrite = 1; c.aluop = 2'b10; u2 = 1; end
      5'b00100: begin c.alusrc = 1; c.regwrite = 1; c.aluop = 2'b10; end
      5'b00000: begin c.memread = 1; c.memtoreg = 1; c.alusrc = 1; c.regwrite = 1; end
      5'b01000: begin c.memwrite = 1; c.alusrc = 1; u2 = 1; end
      5'b11000: begin c.branch = 1; c.aluop = 2'b01; u2 = 1; end
      5'b11011: begin c.jump = 1; c.regwrite = 1; u1 = 0; end
      5'b11001: begin c.jump = 1; c.jalr = 1; c.alusrc = 1; c.regwrite = 1; end
      5'b00101: begin c.auipc = 1; c.alusrc = 1; c.regwrite = 1; u1 = 0; end
      5'b01101: begin c.lui = 1; c.alusrc = 1; c.regwrite = 1; c.aluop = 2'b11; u1 = 0; end
      5'b11100, 5'b00010, 5'b01010, 5'b10110, 5'b11110: c.sys = 1;
      default: ill = 1'b1;
    endcase
  endtask

  // One cycle: drive ID inputs, compare every output to the model, then clock.
  task automatic step(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] erd, input logic redir, input logic rstv);
    cw_t  cur;
    logic ill, u1, u2, lu, memb;
    logic e_pc, e_ifw, e_ifb, e_pc_ns, e_ifb_ns;
    opcode_id = op; rs1_id = r1; rs2_id = r2; ex_rd = erd;
    redirect_ex = redir; rst = rstv;
    #1;
    decode(op, cur, ill, u1, u2);
    lu   = m_ex.memread && erd != 0 && ((u1 && erd == r1) || (u2 && erd == r2));
    memb = m_mem.memread || m_mem.memwrite;
    if (m_halted)   {e_pc, e_ifw, e_ifb} = 3'b000;
    else if (redir) {e_pc, e_ifw, e_ifb} = 3'b111;
    else if (lu)    {e_pc, e_ifw, e_ifb} = 3'b000;
    else if (memb)  {e_pc, e_ifw, e_ifb} = 3'b011;
    else            {e_pc, e_ifw, e_ifb} = 3'b110;
    e_pc_ns  = !m_halted && (redir || !lu);
    e_ifb_ns = !m_halted && redir;
    check("illegal_id",  32'(illegal_id),  32'(ill));
    check("pc_write",    32'(pc_write),    32'(e_pc));
    check("ifid_write",  32'(ifid_write),  32'(e_ifw));
    check("ifid_bubble", 32'(ifid_bubble), 32'(e_ifb));
    check("ex_ctrl",     32'(ex_ctrl),     32'(m_ex));
    check("mem_flags", 32'({mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg}),
          32'({m_mem.memread, m_mem.memwrite, m_mem.regwrite, m_mem.memtoreg}));
    check("wb_flags", 32'({wb_regwrite, wb_memtoreg}), 32'({m_wb.regwrite, m_wb.memtoreg}));
    check("halted",      32'(halted),      32'(m_halted));
    check("ns_pc_write", 32'(ns_pc_write), 32'(e_pc_ns));
    check("ns_ifid_bubble", 32'(ns_ifid_bubble), 32'(e_ifb_ns));
    check("no_x", 32'($isunknown({illegal_id, pc_write, ifid_write, ifid_bubble, ex_ctrl,
          mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, wb_regwrite,
          wb_memtoreg, halted})), 32'd0);
    $display("cyc=%0d rst=%b op=%b rs1=%0d rs2=%0d exrd=%0d redir=%b pcw=%b ifw=%b ifb=%b ex=%h halted=%b",
             cycle, rstv, op, r1, r2, erd, redir, pc_write, ifid_write, ifid_bubble,
             ex_ctrl, halted);
    @(posedge clk); #1;
    cycle++;
    if (!rstv) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_halted = 1'b0;
    end else begin
      m_halted = m_halted || m_wb.sys;
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = (m_halted_prev(m_halted, m_wb) || redir || lu) ? '0 : cur;
    end
  endtask

  // The ID/EX bubble decision uses the halt state before this edge's update.
  logic halted_before;
  function automatic logic m_halted_prev(input logic h, input cw_t w);
    return halted_before;
  endfunction

  task automatic run(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] erd, input logic redir, input logic rstv);
    halted_before = m_halted;
    step(op, r1, r2, erd, redir, rstv);
  endtask

  logic [4:0] legal_ops [10] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                 5'b11011, 5'b11001, 5'b00101, 5'b01101, 5'b00000};

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0; m_halted = 1'b0; halted_before = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Load-use on x5, then the dependent add issues a cycle late; x0 never stalls.
    run(5'b00000, 5'd1, 5'd0, 5'd0, 0, 1);
    run(5'b01100, 5'd5, 5'd1, 5'd5, 0, 1);
    run(5'b01100, 5'd5, 5'd1, 5'd6, 0, 1);
    run(5'b00000, 5'd1, 5'd0, 5'd0, 0, 1);
    run(5'b01100, 5'd0, 5'd1, 5'd0, 0, 1);
    // Store reaching MEM while R-type sits in ID.
    run(5'b01000, 5'd2, 5'd3, 5'd0, 0, 1);
    run(5'b01100, 5'd4, 5'd4, 5'd9, 0, 1);
    run(5'b01100, 5'd4, 5'd4, 5'd9, 0, 1);
    run(5'b01100, 5'd4, 5'd4, 5'd9, 0, 1);
    // Redirect on top of a load-use hazard.
    run(5'b00000, 5'd1, 5'd0, 5'd0, 0, 1);
    run(5'b11000, 5'd7, 5'd7, 5'd7, 1, 1);
    run(5'b00100, 5'd1, 5'd0, 5'd0, 0, 1);
    // Illegal opcode travels as a bubble.
    run(5'b11111, 5'd1, 5'd2, 5'd0, 0, 1);
    repeat (4) run(5'b00100, 5'd0, 5'd0, 5'd0, 0, 1);
    // ecall retires, halt sticks, then a one-edge reset clears everything.
    run(5'b11100, 5'd0, 5'd0, 5'd0, 0, 1);
    repeat (6) run(5'b01100, 5'd1, 5'd2, 5'd0, 0, 1);
    run(5'b01100, 5'd1, 5'd2, 5'd0, 0, 0);
    run(5'b01100, 5'd1, 5'd2, 5'd0, 0, 1);
    // Opcode sweep with no register matches; reset after each SYSTEM/CUSTOM halt.
    for (int i = 0; i < 32; i++) begin
      run(5'(i), 5'd0, 5'd0, 5'd0, 0, 1);
      run(5'b00100, 5'd0, 5'd0, 5'd0, 0, 1);
      if (halted_before || m_halted || m_wb.sys || m_mem.sys || m_ex.sys)
        repeat (4) run(5'b00100, 5'd0, 5'd0, 5'd0, 0, 1);
      run(5'b00100, 5'd0, 5'd0, 5'd0, 0, 0);
    end
    // Random traffic with small register indices to provoke hazards.
    for (int n = 0; n < 700; n++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                        : legal_ops[$urandom_range(0, 9)];
      run(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
          !($urandom_range(0, 19) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
